// File: rtl/output_buffer_pkg.sv
// Shared router types for the per-output-port packet buffer.
package output_buffer_pkg;

  localparam int OB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [23:0] payload;
  } pkt_t;

  // Status bits gathered from all four buffers at router top.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } ob_status_t;

endpackage

// File: rtl/output_buffer_if.sv
// Crossbar-side put/space handshake plus link-side avail/read pull handshake.
interface output_buffer_if
  import output_buffer_pkg::*;
#(
  parameter int DEPTH = OB_DEPTH_DEFAULT
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             put_outbound;
  pkt_t             pkt_in;
  logic             ready_to_recv;
  logic             pkt_out_avail;
  pkt_t             pkt_out;
  logic             read_outbound;
  logic [CNT_W-1:0] occupancy;
  logic             overflow;
  logic             underflow;
  logic [15:0]      pkt_total;
  logic [CNT_W-1:0] high_water;

  modport slave (
    input  put_outbound, pkt_in, read_outbound,
    output ready_to_recv, pkt_out_avail, pkt_out, occupancy,
           overflow, underflow, pkt_total, high_water
  );

  modport master (
    output put_outbound, pkt_in, read_outbound,
    input  ready_to_recv, pkt_out_avail, pkt_out, occupancy,
           overflow, underflow, pkt_total, high_water
  );

endinterface

// File: rtl/output_buffer_fifo_mem.sv
// DEPTH x pkt_t register array: one synchronous write port, one asynchronous read port.
module ob_fifo_mem
  import output_buffer_pkg::*;
#(
  parameter int DEPTH = OB_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pkt_t          wr_data,
  input  logic [AW-1:0] rd_addr,
  output pkt_t          rd_data
);

  pkt_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/output_buffer.sv
// Per-output-port show-ahead packet FIFO between crossbar and outbound link.
// Optional stats counters (pkt_total, high_water) enabled by OUTPUT_BUFFER_STATS_EN.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int DEPTH = OB_DEPTH_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  output_buffer_if.slave ob
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             overflow_q, underflow_q;
  logic             full, empty, wr_en, rd_en;
  pkt_t             head;

  // full/empty come from registers only so the crossbar can sample space combinationally.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = ob.put_outbound && !full;
  assign rd_en = ob.read_outbound && !empty;

  always_comb begin
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      overflow_q  <= ob.put_outbound && full;
      underflow_q <= ob.read_outbound && empty;
    end
  end

  ob_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ob.pkt_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign ob.ready_to_recv = !full;
  assign ob.pkt_out_avail = !empty;
  assign ob.pkt_out       = empty ? '0 : head;
  assign ob.occupancy     = count;
  assign ob.overflow      = overflow_q;
  assign ob.underflow     = underflow_q;

`ifdef OUTPUT_BUFFER_STATS_EN
  logic [15:0]      total_q;
  logic [CNT_W-1:0] hw_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      total_q <= '0;
      hw_q    <= '0;
    end else begin
      if (wr_en) total_q <= total_q + 16'd1;
      if (count_nxt > hw_q) hw_q <= count_nxt;
    end
  end

  assign ob.pkt_total  = total_q;
  assign ob.high_water = hw_q;
`else
  assign ob.pkt_total  = '0;
  assign ob.high_water = '0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: directed puts/reads, monitor compares consumed heads.
`timescale 1ns/1ps
module tb_output_buffer;
  import output_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  pkt_t exp_q[$];

  always #5 clock = ~clock;

  output_buffer_if #(.DEPTH(4)) ob ();

  output_buffer #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .ob    (ob)
  );

  function automatic pkt_t mk(input int dest);
    pkt_t p;
    p.dest    = 4'(dest);
    p.src     = 4'hA;
    p.payload = 24'(dest * 17 + 3);
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expected packets are queued only when the plan says the put lands.
  task automatic step(input logic put, input int dest, input logic accept, input logic rd);
    ob.put_outbound  = put;
    ob.pkt_in        = put ? mk(dest) : '0;
    ob.read_outbound = rd;
    if (put && accept) exp_q.push_back(mk(dest));
    @(posedge clock);
    #1;
    ob.put_outbound  = 1'b0;
    ob.read_outbound = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every head the link consumes must be the oldest accepted packet.
  always @(negedge clock) begin
    if (!reset && ob.read_outbound && ob.pkt_out_avail) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no packet", ob.pkt_out);
      end else begin
        check("pkt_out_order", ob.pkt_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ob.put_outbound  = 1'b0;
    ob.pkt_in        = '0;
    ob.read_outbound = 1'b0;

    // 1 reset
    do_reset(2);
    check("rst_occupancy", 32'(ob.occupancy), 0);
    check("rst_ready", 32'(ob.ready_to_recv), 1);
    check("rst_avail", 32'(ob.pkt_out_avail), 0);
    check("rst_pkt_out", ob.pkt_out, 0);
    check("rst_overflow", 32'(ob.overflow), 0);
    check("rst_underflow", 32'(ob.underflow), 0);

    // 2 ordering and first-packet latency
    step(1, 1, 1, 0);
    check("lat_avail", 32'(ob.pkt_out_avail), 1);
    check("lat_pkt_out", ob.pkt_out, mk(1));
    step(1, 2, 1, 0);
    step(1, 3, 1, 0);
    check("ord_occ3", 32'(ob.occupancy), 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("ord_occ_drain", 32'(ob.occupancy), 32'(2 - i));
    end
    check("ord_avail_empty", 32'(ob.pkt_out_avail), 0);
    check("ord_pkt_out_empty", ob.pkt_out, 0);

    // 3 full / overflow, then read+put while full
    for (int i = 0; i < 4; i++) step(1, 10 + i, 1, 0);
    check("full_ready", 32'(ob.ready_to_recv), 0);
    check("full_occ", 32'(ob.occupancy), 4);
    step(1, 5, 0, 0);
    check("ovf_pulse", 32'(ob.overflow), 1);
    check("ovf_occ", 32'(ob.occupancy), 4);
    step(1, 6, 0, 1);
    check("ovf_rdput_occ", 32'(ob.occupancy), 3);
    check("ovf_rdput_pulse", 32'(ob.overflow), 1);
    step(0, 0, 0, 0);
    check("ovf_clear", 32'(ob.overflow), 0);
    check("ovf_ready_again", 32'(ob.ready_to_recv), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("ovf_drained", 32'(ob.pkt_out_avail), 0);

    // 4 simultaneous put+read at occupancy 2, pointers wrap
    step(1, 1, 1, 0);
    step(1, 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 3 + i, 1, 1);
      check("sim_occ", 32'(ob.occupancy), 2);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("sim_drained", 32'(ob.occupancy), 0);

    // 5 underflow, empty put+read, reset mid-operation
    step(0, 0, 0, 1);
    check("udf_pulse", 32'(ob.underflow), 1);
    check("udf_occ", 32'(ob.occupancy), 0);
    step(0, 0, 0, 0);
    check("udf_clear", 32'(ob.underflow), 0);
    step(1, 7, 1, 1);
    check("empty_rdput_occ", 32'(ob.occupancy), 1);
    check("empty_rdput_udf", 32'(ob.underflow), 1);
    check("empty_rdput_head", ob.pkt_out, mk(7));
    step(1, 8, 1, 0);
    step(1, 9, 1, 0);
    do_reset(1);
    check("midrst_occ", 32'(ob.occupancy), 0);
    check("midrst_avail", 32'(ob.pkt_out_avail), 0);
    check("midrst_ready", 32'(ob.ready_to_recv), 1);

    // 6 stats: 5 accepted puts, peak occupancy 3
    step(1, 1, 1, 0);
    step(1, 2, 1, 0);
    step(1, 3, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 4, 1, 0);
    step(1, 5, 1, 0);
    check("stats_occ", 32'(ob.occupancy), 3);
`ifdef OUTPUT_BUFFER_STATS_EN
    check("stats_total", 32'(ob.pkt_total), 5);
    check("stats_high_water", 32'(ob.high_water), 3);
`else
    check("stats_total_off", 32'(ob.pkt_total), 0);
    check("stats_high_water_off", 32'(ob.high_water), 0);
`endif
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("final_empty", 32'(ob.pkt_out_avail), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
